input_conditioner_multi: RTL and testbench

- Parametrised successor to the fixed 4-direction pad conditioner. Takes N_CH raw, already-thresholded active-high button/direction requests.
- Per channel, in order: synchronises, debounces, and emits level, press-pulse and release-pulse outputs.
- Channels selected by DIR_MASK form a direction group, with optional one-hot arbitration and a release lockout window.
- Sits between the analog-threshold front end and game logic (player movement, menu FSMs).

---
 rtl/input_conditioner_multi.sv | 170 +++++++++++++++++
 tb/tb_input_conditioner_multi.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner_multi.sv
// N_CH-channel button/direction conditioner: sync, debounce, level/press/release, direction lockout.
// Optional auto-repeat press pulses: define INPUT_COND_AUTO_REPEAT_EN.
module input_conditioner_multi #(
   parameter int              N_CH          = 8,
   parameter logic [N_CH-1:0] DIR_MASK      = N_CH'(8'h0F),
   parameter int              DEBOUNCE_CYC  = 4,
   parameter int              LOCKOUT_CYC   = 3000,
   parameter int              ONE_HOT       = 1,
   parameter int              REPEAT_DELAY  = 500,
   parameter int              REPEAT_PERIOD = 100
) (
   input  logic            clk,
   input  logic            resetN,
   input  logic [N_CH-1:0] raw_in,
   output logic [N_CH-1:0] level_out,
   output logic [N_CH-1:0] press_pulse,
   output logic [N_CH-1:0] release_pulse,
   output logic            lockout_active
);

   localparam int DB_W = (DEBOUNCE_CYC < 1) ? 1 : $clog2(DEBOUNCE_CYC + 1);
   localparam int LK_W = (LOCKOUT_CYC < 2) ? 1 : $clog2(LOCKOUT_CYC);

   typedef enum logic {NORMAL, LOCKOUT} state_t;

   function automatic logic [DB_W-1:0] sat_inc_db(input logic [DB_W-1:0] v);
      return (&v) ? v : v + DB_W'(1);
   endfunction

   function automatic logic [LK_W-1:0] sat_inc_lk(input logic [LK_W-1:0] v);
      return (&v) ? v : v + LK_W'(1);
   endfunction

   // Isolates the lowest set bit (two's-complement trick).
   function automatic logic [N_CH-1:0] lowest_set(input logic [N_CH-1:0] v);
      return v & (~v + N_CH'(1));
   endfunction

   logic [N_CH-1:0] sync_p0, sync_p1;
   logic [N_CH-1:0] deb, deb_prev;
   logic [N_CH-1:0] dir_req, dir_sel, lvl_nx, rpt_fire;
   logic [LK_W-1:0] lk_cnt;
   logic            rel_edge;
   state_t          state_q, state_nx;

   // Stage p0/p1: two-flop synchroniser
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= raw_in;
         sync_p1 <= sync_p0;
      end
   end

   // Debounce: accept a change only after DEBOUNCE_CYC consecutive mismatching samples
   generate
      if (DEBOUNCE_CYC == 0) begin : g_bypass
         assign deb = sync_p1;
      end else begin : g_deb
         logic [N_CH-1:0] deb_q;
         logic [DB_W-1:0] db_cnt [N_CH];
         always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
               deb_q <= '0;
               for (int i = 0; i < N_CH; i++) db_cnt[i] <= '0;
            end else begin
               for (int i = 0; i < N_CH; i++) begin
                  if (sync_p1[i] == deb_q[i]) begin
                     db_cnt[i] <= '0;
                  end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                     deb_q[i]  <= ~deb_q[i];
                     db_cnt[i] <= '0;
                  end else begin
                     db_cnt[i] <= sat_inc_db(db_cnt[i]);
                  end
               end
            end
         end
         assign deb = deb_q;
      end
   endgenerate

   assign rel_edge = |(deb_prev & ~deb & DIR_MASK);

   // Direction-group FSM: state register and lockout counter
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= NORMAL;
         lk_cnt  <= '0;
      end else begin
         state_q <= state_nx;
         lk_cnt  <= (state_q == LOCKOUT && state_nx == LOCKOUT) ? sat_inc_lk(lk_cnt) : '0;
      end
   end

   always_comb begin
      state_nx = state_q;
      case (state_q)
         NORMAL:  if (rel_edge && LOCKOUT_CYC > 0) state_nx = LOCKOUT;
         LOCKOUT: if (lk_cnt == LK_W'(LOCKOUT_CYC - 1)) state_nx = NORMAL;
         default: state_nx = NORMAL;
      endcase
   end

   // Leaving LOCKOUT re-samples deb on the same edge, so held directions reappear at once.
   always_comb begin
      dir_req        = deb & DIR_MASK;
      dir_sel        = (ONE_HOT != 0) ? lowest_set(dir_req) : dir_req;
      lvl_nx         = (deb & ~DIR_MASK) | ((state_nx == NORMAL) ? dir_sel : '0);
      lockout_active = (state_q == LOCKOUT);
   end

`ifdef INPUT_COND_AUTO_REPEAT_EN
   localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RP_W   = $clog2(RP_MAX + 1);

   logic [RP_W-1:0] rpt_cnt [N_CH];
   logic [N_CH-1:0] rpt_first;

   always_comb begin
      rpt_fire = '0;
      for (int i = 0; i < N_CH; i++)
         rpt_fire[i] = level_out[i] & lvl_nx[i] &
                       ((rpt_cnt[i] + RP_W'(1)) ==
                        (rpt_first[i] ? RP_W'(REPEAT_PERIOD) : RP_W'(REPEAT_DELAY)));
   end

   // First interval is REPEAT_DELAY, later ones REPEAT_PERIOD; cleared whenever not held.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         rpt_first <= '0;
         for (int i = 0; i < N_CH; i++) rpt_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (!(level_out[i] & lvl_nx[i])) begin
               rpt_cnt[i]   <= '0;
               rpt_first[i] <= 1'b0;
            end else if (rpt_fire[i]) begin
               rpt_cnt[i]   <= '0;
               rpt_first[i] <= 1'b1;
            end else begin
               rpt_cnt[i]   <= rpt_cnt[i] + RP_W'(1);
            end
         end
      end
   end
`else
   logic unused_rpt;
   assign unused_rpt = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
   assign rpt_fire   = '0;
`endif

   // Output stage: level register, edge pulses, previous-deb tracking
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         level_out     <= '0;
         press_pulse   <= '0;
         release_pulse <= '0;
         deb_prev      <= '0;
      end else begin
         level_out     <= lvl_nx;
         press_pulse   <= (lvl_nx & ~level_out) | rpt_fire;
         release_pulse <= ~lvl_nx & level_out;
         deb_prev      <= deb;
      end
   end

endmodule

// File: tb/tb_input_conditioner_multi.sv
// Randomised bench for input_conditioner_multi against a sample-history reference model.
module tb_input_conditioner_multi;

   localparam int         DB   = 4;
   localparam int         LK   = 10;
   localparam int         OH   = 1;
   localparam int         RD   = 20;
   localparam int         RP   = 5;
   localparam logic [7:0] DIRM = 8'h0F;

   logic       clk = 1'b0;
   logic       resetN;
   logic [7:0] raw_in, level_out, press_pulse, release_pulse;
   logic       lockout_active;

   always #5 clk = ~clk;

   input_conditioner_multi #(
      .N_CH(8), .DIR_MASK(DIRM), .DEBOUNCE_CYC(DB), .LOCKOUT_CYC(LK),
      .ONE_HOT(OH), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk), .resetN(resetN), .raw_in(raw_in), .level_out(level_out),
      .press_pulse(press_pulse), .release_pulse(release_pulse),
      .lockout_active(lockout_active)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: raw sample history, lockout cycles remaining, hold age per channel
   logic [7:0] hist [0:7];
   logic [7:0] m_deb, m_deb_prev, m_lvl, m_press, m_rel;
   int         m_lock;
   int         m_age [8];

   task automatic model_reset();
      for (int k = 0; k < 8; k++) hist[k] = 8'h00;
      for (int k = 0; k < 8; k++) m_age[k] = 0;
      m_deb = 0; m_deb_prev = 0; m_lvl = 0; m_press = 0; m_rel = 0; m_lock = 0;
   endtask

   task automatic model_step(input logic [7:0] r);
      logic [7:0] deb_now, dirv, pick, new_lvl, fire, rel;
      bit         all_diff;
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = r;
      deb_now = (DB == 0) ? hist[2] : m_deb;
      rel = m_deb_prev & ~deb_now & DIRM;
      if (m_lock > 0) m_lock--;
      else if (rel != 0 && LK > 0) m_lock = LK;
      dirv = deb_now & DIRM;
      pick = 0;
      if (OH != 0) begin
         for (int i = 0; i < 8; i++)
            if (dirv[i] && pick == 0) pick[i] = 1'b1;
      end else pick = dirv;
      new_lvl = (deb_now & ~DIRM) | ((m_lock > 0) ? 8'h00 : pick);
      fire = 0;
      for (int i = 0; i < 8; i++) begin
         if (new_lvl[i] && m_lvl[i]) begin
            m_age[i]++;
`ifdef INPUT_COND_AUTO_REPEAT_EN
            if (m_age[i] == RD || (m_age[i] > RD && (m_age[i] - RD) % RP == 0)) fire[i] = 1'b1;
`endif
         end else m_age[i] = 0;
      end
      m_press = (new_lvl & ~m_lvl) | fire;
      m_rel   = ~new_lvl & m_lvl;
      m_deb_prev = deb_now;
      if (DB > 0) begin
         for (int i = 0; i < 8; i++) begin
            all_diff = 1;
            for (int j = 2; j < DB + 2; j++)
               if (hist[j][i] == m_deb[i]) all_diff = 0;
            if (all_diff) m_deb[i] = ~m_deb[i];
         end
      end
      m_lvl = new_lvl;
   endtask

   task automatic step(input logic [7:0] r);
      raw_in = r;
      @(posedge clk);
      model_step(r);
      #1;
      chk("level", level_out, m_lvl);
      chk("press", press_pulse, m_press);
      chk("release", release_pulse, m_rel);
      chk("lockout", lockout_active, m_lock > 0);
      @(negedge clk);
   endtask

   initial begin
      int         lk_cycles, guard;
      logic [7:0] cur, r;
      resetN = 1'b0;
      raw_in = 8'hFF;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_level", level_out, 0);
      chk("rst_press", press_pulse, 0);
      chk("rst_release", release_pulse, 0);
      chk("rst_lockout", lockout_active, 0);
      resetN = 1'b1;
      repeat (7) step(8'hFF);
      chk("pwrup_level", level_out, 8'hF1);
      chk("pwrup_press", press_pulse, 8'hF1);
      repeat (3) step(8'hFF);
      repeat (25) step(8'h00);

      // short glitch must be filtered, a stable pulse passes after DB+3 edges
      repeat (3) step(8'h20);
      repeat (10) step(8'h00);
      chk("glitch", level_out[5], 0);
      for (int k = 1; k <= 8; k++) begin
         step(8'h20);
         if (k == 6) chk("deb_early", level_out[5], 0);
         if (k == 7) chk("deb_rise", level_out[5], 1);
      end
      repeat (10) step(8'h00);

      // lockout window with a press of dir 1 inside it
      repeat (10) step(8'h01);
      lk_cycles = 0;
      for (int k = 1; k <= 25; k++) begin
         step((k >= 4) ? 8'h02 : 8'h00);
         if (lockout_active) lk_cycles++;
      end
      chk("lk_len", lk_cycles, LK);
      chk("lk_reappear", level_out[1], 1);
      repeat (25) step(8'h00);

      // one-hot arbitration, then release of the winner
      repeat (10) step(8'h06);
      chk("onehot_a", level_out[3:0], 4'b0010);
      repeat (25) step(8'h04);
      chk("onehot_b", level_out[3:0], 4'b0100);
      repeat (25) step(8'h00);

      // reset in the middle of a lockout
      repeat (10) step(8'h01);
      guard = 0;
      while (!lockout_active && guard < 20) begin
         step(8'h00);
         guard++;
      end
      chk("lk_enter", lockout_active, 1);
      repeat (4) step(8'h00);
      resetN = 1'b0;
      #1;
      chk("rst_mid_lk", lockout_active, 0);
      chk("rst_mid_lvl", level_out, 0);
      model_reset();
      @(negedge clk);
      resetN = 1'b1;
      repeat (10) step(8'h00);

      // long hold on a non-direction channel (auto-repeat when enabled)
      repeat (40) step(8'h40);
      repeat (10) step(8'h00);

      // randomised holds with occasional one-cycle glitches
      cur = 8'h00;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 7) == 0) cur = cur ^ (8'h01 << $urandom_range(0, 7));
         r = cur;
         if ($urandom_range(0, 15) == 0) r = cur ^ (8'h01 << $urandom_range(0, 7));
         step(r);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
